// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// State encoding, blank-digit code and a digit-count helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Code driven on every digit of an overflowed result; blanks a segment display.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Smallest digit count d with 10**d > 2**bin_w - 1 (valid for bin_w < 64).
    function automatic int min_digits(input int bin_w);
        longint unsigned lim;
        int              d;
        lim = 64'd10;
        d   = 1;
        for (int i = 0; i < 20; i++) begin
            if (lim < (64'd1 << bin_w)) begin
                lim = lim * 64'd10;
                d   = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more.
// Purely combinational; results stay within 0..12 for legal digit inputs.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock, result after BIN_W edges.
// Results that do not fit in DIGITS raise ovf and blank every output digit.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    state_t            state;
    state_t            next_state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_next;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_acc;
    logic              ovf_next;
    logic              last_shift;
    logic              accept;

    // All digits are corrected in parallel before the shift; the binary part passes through.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr[BIN_W + 4*g +: 4]),
            .dout (sr_adj[BIN_W + 4*g +: 4])
        );
    end

    assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];
    assign sr_next           = {sr_adj[SR_W-2:0], 1'b0};
    // A one leaving the top digit means the running value has reached 10**DIGITS.
    assign ovf_next          = ovf_acc | sr_adj[SR_W-1];
    assign last_shift        = (state == SHIFT) && (cnt == CNT_W'(BIN_W - 1));
    assign accept            = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            sr      <= {{BCD_W{1'b0}}, in_data};
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (state == SHIFT) begin
            sr      <= sr_next;
            ovf_acc <= ovf_next;
            if (last_shift) begin
                bcd <= ovf_next ? {DIGITS{BCD_BLANK}} : sr_next[SR_W-1 -: BCD_W];
                ovf <= ovf_next;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq in three configurations: 16/5, 8/2 (overflow) and 8/3 (sweep).
// Expected results come from decimal arithmetic on the accepted operand.
module tb_bin2bcd_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    localparam int NK = 3;
    int BW[NK] = '{16, 8, 8};
    int DG[NK] = '{5, 2, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid[NK];
    logic        out_ready[NK];
    logic [15:0] in_data[NK];
    logic        in_ready[NK];
    logic        out_valid[NK];
    logic        ovf[NK];
    logic        busy[NK];
    logic [19:0] bcd_w[NK];
    logic [19:0] bcd0;
    logic [7:0]  bcd1;
    logic [11:0] bcd2;

    exp_t        sbq[NK][$];
    logic [19:0] held[NK];
    logic        prev_ov[NK];
    int          last_acc[NK];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          hs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .bcd(bcd0), .ovf(ovf[0]), .busy(busy[0]));

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .bcd(bcd1), .ovf(ovf[1]), .busy(busy[1]));

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2][7:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .bcd(bcd2), .ovf(ovf[2]), .busy(busy[2]));

    assign bcd_w[0] = bcd0;
    assign bcd_w[1] = {12'h000, bcd1};
    assign bcd_w[2] = {8'h00, bcd2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Decimal reference: digits by repeated division, blanked when out of range.
    function automatic void ref_model(input int v, input int dg, output logic [19:0] b, output logic o);
        int lim;
        int r;
        lim = 1;
        for (int i = 0; i < dg; i++) lim = lim * 10;
        b = '0;
        o = (v >= lim);
        r = v;
        for (int i = 0; i < dg; i++) begin
            b[4*i +: 4] = o ? 4'hF : 4'(r % 10);
            r = r / 10;
        end
    endfunction

    // Input side of the scoreboard: every accepted operand queues its expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < NK; k++) begin
                if (in_valid[k] && in_ready[k]) begin
                    ref_model(int'(in_data[k]) & ((1 << BW[k]) - 1), DG[k], e.bcd, e.ovf);
                    e.acc = cyc + 1;
                    last_acc[k] = cyc + 1;
                    sbq[k].push_back(e);
                end
            end
        end
    end

    // Output side: compare on each new result, then check it stays put while stalled.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NK; k++) begin
            if (!rst_n) begin
                prev_ov[k] = 1'b0;
            end else begin
                if (out_valid[k]) begin
                    chk("in_ready_in_done", 32'(in_ready[k]), 32'd0);
                    if (!prev_ov[k]) begin
                        if (sbq[k].size() == 0) begin
                            chk("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = sbq[k].pop_front();
                            chk($sformatf("bcd[%0d]", k), 32'(bcd_w[k]), 32'(e.bcd));
                            chk($sformatf("ovf[%0d]", k), 32'(ovf[k]), 32'(e.ovf));
                            chk($sformatf("latency[%0d]", k), 32'(cyc - e.acc), 32'(BW[k]));
                        end
                        held[k] = bcd_w[k];
                    end else begin
                        chk($sformatf("bcd_stable[%0d]", k), 32'(bcd_w[k]), 32'(held[k]));
                    end
                end
                prev_ov[k] = out_valid[k];
            end
        end
    end

    task automatic send(input int k, input logic [15:0] v);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = v;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[k] && n < 200);
        if (!in_ready[k]) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((sbq[k].size() != 0 || out_valid[k]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain[%0d]", k), 32'(sbq[k].size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < NK; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
            prev_ov[k]   = 1'b0;
            last_acc[k]  = 0;
        end
        #12;
        for (int k = 0; k < NK; k++) begin
            chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
            chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
            chk("rst_bcd", 32'(bcd_w[k]), 32'd0);
            chk("rst_ovf", 32'(ovf[k]), 32'd0);
        end
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 16'd0);
        send(0, 16'd65535);
        send(0, 16'd10);
        send(0, 16'd9);
        for (int i = 0; i < 20; i++) send(0, 16'($urandom_range(0, 65535)));

        send(1, 16'd99);
        send(1, 16'd100);
        send(1, 16'd255);
        for (int i = 0; i < 20; i++) send(1, 16'($urandom_range(0, 255)));

        drain(0);
        out_ready[0] = 1'b0;
        send(0, 16'd4096);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
        hs = 0;
        fork
            send(0, 16'd777);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
                out_ready[0] = 1'b1;
                hs = cyc + 1;
            end
        join
        chk("accept_after_done", 32'(last_acc[0] - hs), 32'd1);

        drain(0);
        drain(1);
        send(0, 16'd1234);
        repeat (6) @(posedge clk);
        #3;
        chk("mid_shift_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("arst_bcd", 32'(bcd_w[0]), 32'd0);
        chk("arst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        sbq[0].delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 16'd4321);

        for (int v = 0; v < 256; v++) send(2, 16'(v));

        for (int k = 0; k < NK; k++) drain(k);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
